datapath: RTL and testbench

- 32-bit single-bus CPU datapath slice (Phase-1 style) for bring-up of register transfers and one ALU operation.
- Contents: general registers R2, R4 and R5, plus PC, IR, MAR, MDR, Y, a 64-bit Z, and a minimal ALU (AND, PC increment).
- An external control sequencer drives all register enables and tri-state-style "out" selects every cycle.
- Memory is modelled by the Mdatain input bus; there is no internal memory.

---
 rtl/datapath.sv | 111 +++++++++++
 tb/tb_datapath.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/datapath.sv
// Single-bus 32-bit CPU datapath slice: general registers R2/R4/R5, PC, IR, MAR, MDR, Y,
// a double-width Z and a two-operation ALU, all steered by an external control sequencer.
module datapath #(
   parameter int WIDTH = 32
) (
   input  logic                 Clock,
   input  logic                 Reset,
   input  logic                 PCout,
   input  logic                 Zlowout,
   input  logic                 MDRout,
   input  logic                 R2out,
   input  logic                 R4out,
   input  logic                 MARin,
   input  logic                 Zin,
   input  logic                 PCin,
   input  logic                 MDRin,
   input  logic                 IRin,
   input  logic                 Yin,
   input  logic                 IncPC,
   input  logic                 Read,
   input  logic                 AND,
   input  logic                 R5in,
   input  logic                 R2in,
   input  logic                 R4in,
   input  logic [WIDTH-1:0]     Mdatain,
   output logic [WIDTH-1:0]     BusMuxOut,
   output logic [WIDTH-1:0]     PC_q,
   output logic [WIDTH-1:0]     IR_q,
   output logic [WIDTH-1:0]     MAR_q,
   output logic [WIDTH-1:0]     MDR_q,
   output logic [WIDTH-1:0]     Y_q,
   output logic [WIDTH-1:0]     R2_q,
   output logic [WIDTH-1:0]     R4_q,
   output logic [WIDTH-1:0]     R5_q,
   output logic [2*WIDTH-1:0]   Z_q
);

   logic [2*WIDTH-1:0] aluResult;
   logic [WIDTH-1:0]   PC_d, IR_d, MAR_d, MDR_d, Y_d, R2_d, R4_d, R5_d;
   logic [2*WIDTH-1:0] Z_d;

   // Bus mux stands in for tri-state drivers; fixed priority resolves overlapping out selects.
   always_comb begin
      BusMuxOut = '0;
      if (Zlowout)
         BusMuxOut = Z_q[WIDTH-1:0];
      else if (MDRout)
         BusMuxOut = MDR_q;
      else if (PCout)
         BusMuxOut = PC_q;
      else if (R2out)
         BusMuxOut = R2_q;
      else if (R4out)
         BusMuxOut = R4_q;
   end

   // ALU upper half is always zero for the supported ops; the increment wraps at WIDTH bits.
   always_comb begin
      aluResult = '0;
      if (IncPC)
         aluResult = {{WIDTH{1'b0}}, BusMuxOut + {{(WIDTH-1){1'b0}}, 1'b1}};
      else if (AND)
         aluResult = {{WIDTH{1'b0}}, Y_q & BusMuxOut};
   end

   always_comb begin
      PC_d  = PC_q;
      IR_d  = IR_q;
      MAR_d = MAR_q;
      MDR_d = MDR_q;
      Y_d   = Y_q;
      R2_d  = R2_q;
      R4_d  = R4_q;
      R5_d  = R5_q;
      Z_d   = Z_q;
      if (PCin)  PC_d  = BusMuxOut;
      if (IRin)  IR_d  = BusMuxOut;
      if (MARin) MAR_d = BusMuxOut;
      if (MDRin) MDR_d = Read ? Mdatain : BusMuxOut;
      if (Yin)   Y_d   = BusMuxOut;
      if (R2in)  R2_d  = BusMuxOut;
      if (R4in)  R4_d  = BusMuxOut;
      if (R5in)  R5_d  = BusMuxOut;
      if (Zin)   Z_d   = aluResult;
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         PC_q  <= '0;
         IR_q  <= '0;
         MAR_q <= '0;
         MDR_q <= '0;
         Y_q   <= '0;
         R2_q  <= '0;
         R4_q  <= '0;
         R5_q  <= '0;
         Z_q   <= '0;
      end else begin
         PC_q  <= PC_d;
         IR_q  <= IR_d;
         MAR_q <= MAR_d;
         MDR_q <= MDR_d;
         Y_q   <= Y_d;
         R2_q  <= R2_d;
         R4_q  <= R4_d;
         R5_q  <= R5_d;
         Z_q   <= Z_d;
      end
   end

endmodule

// File: tb/tb_datapath.sv
// Scoreboard bench for the datapath: expected register values are queued as each cycle's
// controls are driven and compared just after the edge that should produce them.
module tb_datapath;

   localparam int WIDTH = 32;

   localparam int ID_PC  = 0;
   localparam int ID_IR  = 1;
   localparam int ID_MAR = 2;
   localparam int ID_MDR = 3;
   localparam int ID_Y   = 4;
   localparam int ID_R2  = 5;
   localparam int ID_R4  = 6;
   localparam int ID_R5  = 7;
   localparam int ID_Z   = 8;

   typedef struct {
      string       tag;
      int          id;
      logic [63:0] value;
   } expect_t;

   logic Clock, Reset;
   logic PCout, Zlowout, MDRout, R2out, R4out;
   logic MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read, AND, R5in, R2in, R4in;
   logic [WIDTH-1:0]   Mdatain, BusMuxOut;
   logic [WIDTH-1:0]   PC_q, IR_q, MAR_q, MDR_q, Y_q, R2_q, R4_q, R5_q;
   logic [2*WIDTH-1:0] Z_q;

   expect_t scoreboard[$];
   int checkCount = 0;
   int errorCount = 0;

   datapath #(.WIDTH(WIDTH)) dut (
      .Clock(Clock), .Reset(Reset),
      .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .R2out(R2out), .R4out(R4out),
      .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
      .IncPC(IncPC), .Read(Read), .AND(AND), .R5in(R5in), .R2in(R2in), .R4in(R4in),
      .Mdatain(Mdatain), .BusMuxOut(BusMuxOut),
      .PC_q(PC_q), .IR_q(IR_q), .MAR_q(MAR_q), .MDR_q(MDR_q), .Y_q(Y_q),
      .R2_q(R2_q), .R4_q(R4_q), .R5_q(R5_q), .Z_q(Z_q)
   );

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   // Every comparison funnels through here so the counts stay honest.
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [63:0] readReg(input int id);
      case (id)
         ID_PC:   return {32'b0, PC_q};
         ID_IR:   return {32'b0, IR_q};
         ID_MAR:  return {32'b0, MAR_q};
         ID_MDR:  return {32'b0, MDR_q};
         ID_Y:    return {32'b0, Y_q};
         ID_R2:   return {32'b0, R2_q};
         ID_R4:   return {32'b0, R4_q};
         ID_R5:   return {32'b0, R5_q};
         default: return Z_q;
      endcase
   endfunction

   task automatic expectReg(input string tag, input int id, input logic [63:0] value);
      expect_t e;
      e.tag = tag;
      e.id = id;
      e.value = value;
      scoreboard.push_back(e);
   endtask

   task automatic clearControls();
      Reset = 0; PCout = 0; Zlowout = 0; MDRout = 0; R2out = 0; R4out = 0;
      MARin = 0; Zin = 0; PCin = 0; MDRin = 0; IRin = 0; Yin = 0;
      IncPC = 0; Read = 0; AND = 0; R5in = 0; R2in = 0; R4in = 0;
      Mdatain = '0;
   endtask

   // Clock the queued controls in, then drain the scoreboard against the new register state.
   task automatic applyStimulus();
      expect_t e;
      @(posedge Clock);
      #1;
      while (scoreboard.size() > 0) begin
         e = scoreboard.pop_front();
         checkOutput(e.tag, readReg(e.id), e.value);
      end
      clearControls();
   endtask

   task automatic loadMdr(input logic [31:0] value);
      Read = 1; MDRin = 1; Mdatain = value;
      expectReg("mdrLoad", ID_MDR, {32'b0, value});
      applyStimulus();
   endtask

   task automatic expectAllZero(input string tag);
      for (int i = 0; i <= ID_Z; i++) expectReg(tag, i, 64'h0);
   endtask

   initial begin
      clearControls();
      Reset = 1;
      expectAllZero("reset");
      applyStimulus();

      // Preload R2/R4/R5 through MDR
      loadMdr(32'h22);
      MDRout = 1; R2in = 1; expectReg("preR2", ID_R2, 64'h22); applyStimulus();
      loadMdr(32'h24);
      MDRout = 1; R4in = 1; expectReg("preR4", ID_R4, 64'h24); applyStimulus();
      loadMdr(32'h26);
      MDRout = 1; R5in = 1; expectReg("preR5", ID_R5, 64'h26); applyStimulus();

      // AND fetch/execute T0..T5
      PCout = 1; MARin = 1; IncPC = 1; Zin = 1;
      expectReg("t0Mar", ID_MAR, 64'h0); expectReg("t0Z", ID_Z, 64'h1); applyStimulus();
      Zlowout = 1; PCin = 1; Read = 1; MDRin = 1; Mdatain = 32'h4A920000;
      expectReg("t1Pc", ID_PC, 64'h1); expectReg("t1Mdr", ID_MDR, 64'h4A920000); applyStimulus();
      MDRout = 1; IRin = 1;
      expectReg("t2Ir", ID_IR, 64'h4A920000); applyStimulus();
      R2out = 1; Yin = 1;
      expectReg("t3Y", ID_Y, 64'h22); applyStimulus();
      R4out = 1; AND = 1; Zin = 1;
      expectReg("t4Z", ID_Z, 64'h20); applyStimulus();
      Zlowout = 1; R5in = 1;
      expectReg("t5R5", ID_R5, 64'h20); expectReg("t5Mar", ID_MAR, 64'h0);
      expectReg("t5Pc", ID_PC, 64'h1); applyStimulus();

      // PC increment wrap
      loadMdr(32'hFFFFFFFF);
      MDRout = 1; PCin = 1; expectReg("wrapPcLoad", ID_PC, 64'hFFFFFFFF); applyStimulus();
      PCout = 1; IncPC = 1; Zin = 1; expectReg("wrapZ", ID_Z, 64'h0); applyStimulus();
      Zlowout = 1; PCin = 1; expectReg("wrapPc", ID_PC, 64'h0); applyStimulus();

      // Bus priority ladder
      loadMdr(32'h77);
      MDRout = 1; PCin = 1; expectReg("prioPc", ID_PC, 64'h77); applyStimulus();
      PCout = 1; IncPC = 1; Zin = 1; expectReg("prioZ", ID_Z, 64'h78); applyStimulus();
      loadMdr(32'h9);
      MDRout = 1; R2in = 1; expectReg("prioR2", ID_R2, 64'h9); applyStimulus();
      loadMdr(32'h5);
      Zlowout = 1; MDRout = 1; PCout = 1; R2out = 1; R4out = 1; Yin = 1;
      expectReg("prioZlow", ID_Y, 64'h78); applyStimulus();
      MDRout = 1; PCout = 1; R2out = 1; R4out = 1; Yin = 1;
      expectReg("prioMdr", ID_Y, 64'h5); applyStimulus();
      PCout = 1; R2out = 1; R4out = 1; Yin = 1;
      expectReg("prioPcOut", ID_Y, 64'h77); applyStimulus();
      R2out = 1; R4out = 1; Yin = 1;
      expectReg("prioR2Out", ID_Y, 64'h9); applyStimulus();
      R4out = 1; Yin = 1;
      expectReg("prioR4Out", ID_Y, 64'h24); applyStimulus();
      Yin = 1;
      expectReg("busIdle", ID_Y, 64'h0); applyStimulus();

      // MDR mux selects bus when Read is low
      Read = 0; R4out = 1; MDRin = 1; Mdatain = 32'hDEAD;
      expectReg("mdrMuxBus", ID_MDR, 64'h24); applyStimulus();

      // ALU op priority and AND with a distinct operand
      loadMdr(32'h3C);
      MDRout = 1; Yin = 1; expectReg("aluY", ID_Y, 64'h3C); applyStimulus();
      R4out = 1; AND = 1; Zin = 1; expectReg("aluAnd", ID_Z, 64'h24); applyStimulus();
      R4out = 1; AND = 1; IncPC = 1; Zin = 1; expectReg("aluIncPrio", ID_Z, 64'h25); applyStimulus();
      Zin = 0; R2out = 1; expectReg("zHold", ID_Z, 64'h25); applyStimulus();

      // Same-cycle read and write of MDR: bus carries the old value
      MDRout = 1; Yin = 1; Read = 1; MDRin = 1; Mdatain = 32'h11;
      expectReg("noBypassY", ID_Y, 64'h3C); expectReg("noBypassMdr", ID_MDR, 64'h11); applyStimulus();

      // Reset in the middle of a sequence
      PCout = 1; MARin = 1; IncPC = 1; Zin = 1; applyStimulus();
      Zlowout = 1; PCin = 1; Read = 1; MDRin = 1; Mdatain = 32'h4A920000; applyStimulus();
      MDRout = 1; IRin = 1; applyStimulus();
      R2out = 1; Yin = 1; Reset = 1;
      expectAllZero("midReset"); applyStimulus();
      loadMdr(32'h33);
      MDRout = 1; R2in = 1; expectReg("postResetR2", ID_R2, 64'h33); applyStimulus();
      R2out = 1; AND = 1; Zin = 1; expectReg("postResetAnd", ID_Z, 64'h0); applyStimulus();

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
